// File: rtl/ringbuf_fir_reader_if.sv
// Bus bundle between the FIR reader, the delay-line ring buffer, the
// coefficient ROM and the downstream mixer. The reader takes the slave view.
interface ringbuf_fir_reader_if #(
  parameter int NTAPS_LOG2 = 4,
  parameter int COEFF_W    = 16
) ();
  logic                  start_i;
  logic [NTAPS_LOG2-1:0] rb_offset_o;
  logic                  rb_pop_o;
  logic [23:0]           rb_data_i;
  logic [NTAPS_LOG2-1:0] coeff_addr_o;
  logic [COEFF_W-1:0]    coeff_i;
  logic [23:0]           data_o;
  logic                  valid_o;
  logic                  busy_o;

  modport slave (
    input  start_i, rb_data_i, coeff_i,
    output rb_offset_o, rb_pop_o, coeff_addr_o, data_o, valid_o, busy_o
  );

  modport master (
    output start_i, rb_data_i, coeff_i,
    input  rb_offset_o, rb_pop_o, coeff_addr_o, data_o, valid_o, busy_o
  );
endinterface

// File: rtl/ringbuf_fir_reader.sv
// FIR read engine for the 24-bit audio delay line: sweeps every tap offset,
// multiply-accumulates against the coefficient ROM, emits one rounded and
// saturated sample, then pops the ring buffer once to advance the window.
//
// state | meaning
// IDLE  | waiting for start_i
// ISSUE | driving tap offsets 0..NTAPS-1, accumulating returned taps
// DRAIN | last tap returning; result rounded/saturated into data_o
// DONE  | valid_o and rb_pop_o strobe for one cycle
module ringbuf_fir_reader #(
  parameter int NTAPS      = 16,
  parameter int NTAPS_LOG2 = 4,
  parameter int COEFF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ringbuf_fir_reader_if.slave  bus
);

  localparam int PROD_W = 24 + COEFF_W;
  localparam int ACC_W  = PROD_W + NTAPS_LOG2;
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) << (COEFF_W - 2);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(8388607);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-8388608);
  localparam logic [NTAPS_LOG2-1:0]   LAST   = NTAPS_LOG2'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                    state, state_nx;
  logic [NTAPS_LOG2-1:0]     idx;
  logic                      tap_vld;
  logic signed [ACC_W-1:0]   acc;
  logic [23:0]               data_q;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   final_sum;
  logic signed [ACC_W-1:0]   rounded;
  logic [23:0]               sat24;

  // Full-precision tap product, accumulate and round/saturate datapath.
  always_comb begin
    prod      = $signed(bus.rb_data_i) * $signed(bus.coeff_i);
    final_sum = acc + {{NTAPS_LOG2{prod[PROD_W-1]}}, prod};
    rounded   = (final_sum + RND) >>> (COEFF_W - 1);
    if (rounded > SAT_HI)
      sat24 = 24'h7FFFFF;
    else if (rounded < SAT_LO)
      sat24 = 24'h800000;
    else
      sat24 = rounded[23:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start_i is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_i) state_nx = ISSUE;
      ISSUE:   if (idx == LAST) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tap index, read-return qualifier, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      tap_vld <= 1'b0;
      acc     <= '0;
      data_q  <= '0;
    end else begin
      tap_vld <= (state == ISSUE);
      if (state == IDLE && bus.start_i) begin
        idx <= '0;
        acc <= '0;
      end else begin
        if (state == ISSUE) idx <= idx + NTAPS_LOG2'(1);
        if (tap_vld)        acc <= final_sum;
      end
      if (state == DRAIN) data_q <= sat24;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus.rb_offset_o  = (state == ISSUE) ? idx : '0;
    bus.coeff_addr_o = (state == ISSUE) ? idx : '0;
    bus.valid_o      = (state == DONE);
    bus.rb_pop_o     = (state == DONE);
    bus.busy_o       = (state != IDLE);
    bus.data_o       = data_q;
  end

endmodule

// File: tb/tb_ringbuf_fir_reader.sv
// Bench for ringbuf_fir_reader: ring buffer + coefficient ROM models,
// a transaction-level reference model and a scoreboard monitor.
module tb_ringbuf_fir_reader;
  localparam int NTAPS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ringbuf_fir_reader_if #(.NTAPS_LOG2(4), .COEFF_W(16)) bus ();

  ringbuf_fir_reader #(.NTAPS(16), .NTAPS_LOG2(4), .COEFF_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [23:0] mem  [256];
  logic [15:0] coef [16];
  logic [7:0]  tbase = 8'd0;
  logic [7:0]  mbase = 8'd0;

  typedef struct { logic [23:0] d; int c; } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n0 = 0;
  int n_acc = 0;
  bit active = 0;
  logic [23:0] last_data = 24'd0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic logic [23:0] fir_ref(input logic [7:0] b);
    longint sum, r;
    sum = 0;
    for (int k = 0; k < NTAPS; k++)
      sum += longint'($signed(mem[8'(b + 8'(k))])) * longint'($signed(coef[k]));
    r = (sum + 64'sd16384) >>> 15;
    if (r > 64'sd8388607) r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    return r[23:0];
  endfunction

  // Ring buffer and coefficient ROM: registered reads, pop advances window.
  always @(posedge clk) begin
    bus.rb_data_i <= mem[8'(tbase + 8'(bus.rb_offset_o))];
    bus.coeff_i   <= coef[bus.coeff_addr_o];
    if (bus.rb_pop_o) tbase <= tbase + 8'd1;
  end

  // Reference model: accept start when idle, result due 17 edges later,
  // window advances one edge after that, next start earliest the edge after.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      active = 0;
    end else if (!active) begin
      if (bus.start_i) begin
        n0 = cyc;
        active = 1;
        n_acc++;
        q.push_back('{fir_ref(mbase), cyc + NTAPS + 1});
      end
    end else if (cyc == n0 + NTAPS + 2) begin
      active = 0;
      mbase = mbase + 8'd1;
    end
  end

  // Monitor: per-cycle control checks and scoreboard pop on valid_o.
  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      int eoff;
      exp_t e;
      ev   = active && (cyc == n0 + NTAPS + 1);
      eoff = (active && (cyc - n0) < NTAPS) ? (cyc - n0) : 0;
      chk("valid_o", bus.valid_o, ev);
      chk("rb_pop_o", bus.rb_pop_o, ev);
      chk("busy_o", bus.busy_o, active);
      chk("rb_offset_o", bus.rb_offset_o, eoff);
      chk("coeff_addr_o", bus.coeff_addr_o, eoff);
      if (bus.valid_o) begin
        last_data = bus.data_o;
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data_o", bus.data_o, e.d);
          chk("latency", cyc, e.c);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (active && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (active) begin
      checks++;
      $display("FAIL timeout: still busy after %0d cycles want idle", t);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input logic [23:0] d, input int tap, input logic [15:0] c, input bit all_c);
    for (int i = 0; i < 256; i++) mem[i] = d;
    for (int k = 0; k < NTAPS; k++) coef[k] = (all_c || k == tap) ? c : 16'h0000;
  endtask

  task automatic randomize_all();
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    for (int k = 0; k < NTAPS; k++) begin
      case ($urandom_range(0, 5))
        0:       coef[k] = 16'h7FFF;
        1:       coef[k] = 16'h8000;
        2:       coef[k] = 16'h0000;
        default: coef[k] = 16'($urandom);
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_o"}, bus.data_o, 0);
    chk({tag, "_valid_o"}, bus.valid_o, 0);
    chk({tag, "_rb_pop_o"}, bus.rb_pop_o, 0);
    chk({tag, "_rb_offset_o"}, bus.rb_offset_o, 0);
    chk({tag, "_coeff_addr_o"}, bus.coeff_addr_o, 0);
    chk({tag, "_busy_o"}, bus.busy_o, 0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    randomize_all();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill(24'h100000, 0, 16'h7FFF, 0);
    pulse_start(); wait_idle();
    chk("unity_tap", last_data, 24'h0FFFE0);

    fill(24'h000100, 3, 16'h8000, 0);
    pulse_start(); wait_idle();
    chk("negation", last_data, 24'hFFFF00);

    fill(24'h7FFFFF, 0, 16'h7FFF, 1);
    pulse_start(); wait_idle();
    chk("sat_pos", last_data, 24'h7FFFFF);

    fill(24'h800000, 0, 16'h7FFF, 1);
    pulse_start(); wait_idle();
    chk("sat_neg", last_data, 24'h800000);

    // Starts at cycles 3 and 10 into a sweep must be dropped.
    randomize_all();
    pulse_start();
    repeat (2) @(negedge clk);
    bus.start_i = 1'b1; @(negedge clk); bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    bus.start_i = 1'b1; @(negedge clk); bus.start_i = 1'b0;
    wait_idle();

    // Back-to-back: start held high, four results.
    begin
      int target, t;
      randomize_all();
      target = n_acc + 4;
      t = 0;
      @(negedge clk);
      bus.start_i = 1'b1;
      while (n_acc < target && t < 200) begin
        @(negedge clk);
        t++;
      end
      bus.start_i = 1'b0;
      chk("b2b_accepted", n_acc, target);
      wait_idle();
    end

    // Randomized transactions with random gaps.
    for (int j = 0; j < 20; j++) begin
      randomize_all();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      wait_idle();
    end

    // Reset while idx = 7, then a clean transaction.
    randomize_all();
    pulse_start();
    repeat (7) @(negedge clk);
    chk("pre_reset_offset", bus.rb_offset_o, 7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midop_reset");
    active = 0;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    randomize_all();
    pulse_start();
    wait_idle();

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
